message_schedule: RTL

SHA-256 message schedule expander, directly downstream of `message_build`. It accepts padded 512-bit message blocks over a valid/ready handshake and emits the 64 schedule words W0..W63 of each block, one 32-bit word per output handshake, to the compression stage. Message framing is preserved: `data_out_last` marks W63 of the final block of a message.

---
 rtl/sha256_pkg.sv | 38 +++
 rtl/message_schedule.sv | 112 +++++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: schedule FSM states, sizing constants and the
// sigma/Sigma mixing functions used by the schedule and compression stages.
package sha256_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ROUNDS  = 64;
    localparam int unsigned WIN_N   = 16;
    localparam int unsigned BLOCK_W = WORD_W * WIN_N;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned WIN_W   = 4;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [WORD_W-1:0] sha256_sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [WORD_W-1:0] sha256_sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Sigma0: ROTR2 ^ ROTR13 ^ ROTR22
    function automatic logic [WORD_W-1:0] sha256_big_sigma0(input logic [WORD_W-1:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    // Sigma1: ROTR6 ^ ROTR11 ^ ROTR25
    function automatic logic [WORD_W-1:0] sha256_big_sigma1(input logic [WORD_W-1:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

endpackage

// File: rtl/message_schedule.sv
// SHA-256 message schedule expander.
// Accepts one padded 512-bit block per input handshake and emits W0..W63,
// one word per output handshake, from a 16-word sliding window.
// Ports:
//   clk, nrst (async, active-low), sync_rst (sync, active-high)
//   data_in[511:0], data_in_last, data_in_valid, data_in_ready  - block input
//   data_out[31:0], data_out_index[5:0], data_out_last,
//   data_out_valid, data_out_ready                              - word output
module message_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    input  logic         sync_rst,
    input  logic [511:0] data_in,
    input  logic         data_in_last,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    output logic [31:0]  data_out,
    output logic [5:0]   data_out_index,
    output logic         data_out_last,
    output logic         data_out_valid,
    input  logic         data_out_ready
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] IDX_PRE  = IDX_W'(ROUNDS - 2);

    state_t                        state;
    logic [WORD_W-1:0]             w [WIN_N];
    logic [IDX_W-1:0]              cnt;
    logic                          last_flag;
    logic                          out_last_q;
    logic [WIN_N-1:0][WORD_W-1:0]  blk_c;
    logic [WORD_W-1:0]             w_next_c;
    logic                          out_hs_c;

    // Word 0 of the block sits in the top 32 bits.
    assign blk_c    = data_in;
    assign w_next_c = sha256_sigma1(w[14]) + w[9] + sha256_sigma0(w[1]) + w[0];
    assign out_hs_c = data_out_valid & data_out_ready;

    // Output word and index come straight from the window head and counter.
    assign data_out       = w[0];
    assign data_out_index = cnt;
    assign data_out_last  = out_last_q;

    // Control FSM, window and counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= ST_INIT;
            data_in_ready  <= 1'b0;
            data_out_valid <= 1'b0;
            out_last_q     <= 1'b0;
            last_flag      <= 1'b0;
            cnt            <= '0;
            for (int unsigned i = 0; i < WIN_N; i++) w[WIN_W'(i)] <= '0;
        end else if (sync_rst) begin
            state          <= ST_INIT;
            data_in_ready  <= 1'b0;
            data_out_valid <= 1'b0;
            out_last_q     <= 1'b0;
            last_flag      <= 1'b0;
            cnt            <= '0;
            for (int unsigned i = 0; i < WIN_N; i++) w[WIN_W'(i)] <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    state         <= ST_IDLE;
                    data_in_ready <= 1'b1;
                end
                ST_IDLE: begin
                    if (data_in_valid) begin
                        for (int unsigned i = 0; i < WIN_N; i++)
                            w[WIN_W'(i)] <= blk_c[WIN_W'(WIN_N - 1 - i)];
                        last_flag      <= data_in_last;
                        cnt            <= '0;
                        out_last_q     <= 1'b0;
                        data_out_valid <= 1'b1;
                        data_in_ready  <= 1'b0;
                        state          <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_hs_c) begin
                        // Slide the window; the new tail is W(t+16).
                        for (int unsigned i = 0; i < WIN_N - 1; i++)
                            w[WIN_W'(i)] <= w[WIN_W'(i + 1)];
                        w[WIN_W'(WIN_N - 1)] <= w_next_c;
                        cnt <= cnt + IDX_W'(1);
                        if (cnt == IDX_LAST) begin
                            data_out_valid <= 1'b0;
                            data_in_ready  <= 1'b1;
                            out_last_q     <= 1'b0;
                            state          <= ST_IDLE;
                        end else begin
                            // Last is raised as the counter steps onto 63.
                            out_last_q <= last_flag & (cnt == IDX_PRE);
                        end
                    end
                end
                default: begin
                    state          <= ST_INIT;
                    data_in_ready  <= 1'b0;
                    data_out_valid <= 1'b0;
                    out_last_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule
